lsu_dmem_port: RTL and testbench

Load/store unit on the data side of the pipelined core's MEM stage: takes the MEM-stage access request (read/write enable, ALU address, store data, funct3), converts it into a word-aligned bus transaction with byte enables to an external data memory using a req/gnt/rvalid handshake, and returns an aligned, sign- or zero-extended load result. While a bus transaction is outstanding it drives a stall that freezes the whole pipeline. Misaligned or unsupported accesses are rejected without touching the bus.

---
 rtl/lsu_pkg.sv | 31 +++
 rtl/lsu_dmem_port_load_align.sv | 27 ++
 rtl/lsu_dmem_port.sv | 150 +++++++++++++++
 tb/tb_lsu_dmem_port.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: access encodings,
// FSM state type and the access legality rule.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_R,
    ST_DONE
  } lsu_state_t;

  // Unsupported size/sign for the direction, or an address not aligned to the size.
  function automatic logic access_illegal(input logic       is_wr,
                                          input logic [2:0] f3,
                                          input logic [1:0] addr_lo);
    logic bad_f3;
    logic misaligned;
    if (is_wr) bad_f3 = !(f3 inside {F3_B, F3_H, F3_W});
    else       bad_f3 = !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    misaligned = ((f3 == F3_H || f3 == F3_HU) && addr_lo[0]) ||
                 ((f3 == F3_W) && (addr_lo != 2'b00));
    return bad_f3 || misaligned;
  endfunction

endpackage

// File: rtl/lsu_dmem_port_load_align.sv
// Selects the addressed byte/half/word lane of a read word and applies
// sign or zero extension according to the load type.
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] bus_rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'(bus_rdata >> {addr_lo, 3'b000});
    half_sel = addr_lo[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (funct3)
      F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    data = {{16{half_sel[15]}}, half_sel};
      F3_BU:   data = {24'h0, byte_sel};
      F3_HU:   data = {16'h0, half_sel};
      default: data = bus_rdata;
    endcase
  end

endmodule

// File: rtl/lsu_dmem_port.sv
// MEM-stage data port: turns a load/store request into one registered
// req/gnt/rvalid bus transaction and stalls the pipeline until it completes.
module lsu_dmem_port
  import lsu_pkg::*;
#(
  parameter logic [31:0] RDATA_RST = 32'h0000_0000
) (
  input  logic        CLOCK,
  input  logic        RST_n,
  input  logic        ena_rd,
  input  logic        ena_wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  funct3,
  output logic [31:0] rdata,
  output logic        lsu_stall,
  output logic        lsu_fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  lsu_state_t  state_q, state_d;
  logic        access;
  logic        illegal;
  logic        accept;
  logic        capture;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [2:0]  funct3_q;
  logic [1:0]  addr_lo_q;
  logic [31:0] align_data;

  assign access  = ena_rd | ena_wr;
  assign illegal = access_illegal(ena_wr, funct3, addr[1:0]);

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    lsu_stall = 1'b0;
    lsu_fault = 1'b0;
    accept    = 1'b0;
    capture   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (access) begin
          if (illegal) begin
            lsu_fault = 1'b1;
          end else begin
            lsu_stall = 1'b1;
            accept    = 1'b1;
            state_d   = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        lsu_stall = 1'b1;
        if (bus_gnt) begin
          if (bus_we) begin
            state_d = ST_DONE;
          end else if (bus_rvalid) begin
            capture = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_WAIT_R;
          end
        end
      end
      ST_WAIT_R: begin
        lsu_stall = 1'b1;
        if (bus_rvalid) begin
          capture = 1'b1;
          state_d = ST_DONE;
        end
      end
      // One unstalled cycle lets the pipeline move past this access before IDLE looks again.
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Lane replication lets the memory take store data from whichever lanes bus_be enables.
  always_comb begin
    be_d    = 4'b1111;
    wdata_d = 32'h0;
    if (ena_wr) begin
      case (funct3)
        F3_B: begin
          be_d    = 4'b0001 << addr[1:0];
          wdata_d = {4{wdata[7:0]}};
        end
        F3_H: begin
          be_d    = 4'b0011 << {addr[1], 1'b0};
          wdata_d = {2{wdata[15:0]}};
        end
        default: wdata_d = wdata;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: all of these are plain registers (no memory array), so each one is
  // reset; an abort leaves the bus quiet and rdata at its reset value.
  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'h0;
      bus_be    <= 4'h0;
      bus_wdata <= 32'h0;
      funct3_q  <= 3'b000;
      addr_lo_q <= 2'b00;
    end else if (accept) begin
      bus_req   <= 1'b1;
      bus_we    <= ena_wr;
      bus_addr  <= {addr[31:2], 2'b00};
      bus_be    <= be_d;
      bus_wdata <= wdata_d;
      funct3_q  <= funct3;
      addr_lo_q <= addr[1:0];
    end else if (state_q == ST_REQ && bus_gnt) begin
      bus_req <= 1'b0;
    end
  end

  load_align u_load_align (
    .bus_rdata (bus_rdata),
    .addr_lo   (addr_lo_q),
    .funct3    (funct3_q),
    .data      (align_data)
  );

  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n)       rdata <= RDATA_RST;
    else if (capture) rdata <= align_data;
  end

endmodule

// File: tb/tb_lsu_dmem_port.sv
// Self-checking bench for lsu_dmem_port: directed cases followed by random
// accesses, all checked against an arithmetic model of the access rules.
module tb_lsu_dmem_port;

  logic        CLOCK;
  logic        RST_n;
  logic        ena_rd;
  logic        ena_wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  funct3;
  logic [31:0] rdata;
  logic        lsu_stall;
  logic        lsu_fault;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  int          checks;
  int          errors;
  logic [31:0] model_rdata;

  lsu_dmem_port dut (
    .CLOCK      (CLOCK),
    .RST_n      (RST_n),
    .ena_rd     (ena_rd),
    .ena_wr     (ena_wr),
    .addr       (addr),
    .wdata      (wdata),
    .funct3     (funct3),
    .rdata      (rdata),
    .lsu_stall  (lsu_stall),
    .lsu_fault  (lsu_fault),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_be     (bus_be),
    .bus_wdata  (bus_wdata),
    .bus_gnt    (bus_gnt),
    .bus_rvalid (bus_rvalid),
    .bus_rdata  (bus_rdata)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // ---- reference model: access size in bytes drives every rule ----
  function automatic int m_size(input logic [2:0] f3);
    return 1 << (f3 & 3'd3);
  endfunction

  function automatic logic m_fault(input logic wr, input logic [2:0] f3, input logic [31:0] a);
    logic legal;
    if (wr) legal = (f3 <= 3'd2);
    else    legal = (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    if (!legal) return 1'b1;
    return (a % m_size(f3)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic wr, input logic [2:0] f3, input logic [31:0] a);
    int mask;
    if (!wr) return 4'hF;
    mask = (1 << m_size(f3)) - 1;
    return 4'(mask << (a % 4));
  endfunction

  function automatic logic [31:0] m_wdata(input logic wr, input logic [2:0] f3, input logic [31:0] wd);
    if (!wr) return 32'h0;
    case (m_size(f3))
      1:       return (wd & 32'hFF) * 32'h0101_0101;
      2:       return (wd & 32'hFFFF) * 32'h0001_0001;
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    int          nb;
    logic [31:0] v;
    logic [31:0] span;
    nb = m_size(f3);
    if (nb == 4) return w;
    span = 32'd1 << (8 * nb);
    v    = (w >> (8 * (a % 4))) & (span - 32'd1);
    if (f3 < 3'd4 && v >= (span >> 1)) v = v - span;
    return v;
  endfunction

  // One complete MEM-stage access; gnt_dly cycles of REQ without grant,
  // rv_dly cycles between grant and read data.
  task automatic run_access(input logic wr, input logic rd, input logic [31:0] a,
                            input logic [31:0] wd, input logic [2:0] f3,
                            input int gnt_dly, input int rv_dly, input logic [31:0] rword);
    logic        fault_e;
    logic [31:0] ld_e;
    int          stall_cycles;
    fault_e      = m_fault(wr, f3, a);
    ld_e         = m_load(f3, a, rword);
    stall_cycles = 0;

    @(negedge CLOCK);
    ena_wr = wr; ena_rd = rd; addr = a; wdata = wd; funct3 = f3;
    #1;
    check1("idle_fault", lsu_fault, fault_e);
    check1("idle_stall", lsu_stall, !fault_e);
    if (lsu_stall) stall_cycles++;

    if (fault_e) begin
      @(negedge CLOCK);
      ena_wr = 1'b0; ena_rd = 1'b0;
      #1;
      check1("fault_no_req", bus_req, 1'b0);
      check1("fault_no_stall", lsu_stall, 1'b0);
      check1("fault_one_pulse", lsu_fault, 1'b0);
      return;
    end

    for (int i = 0; i <= gnt_dly; i++) begin
      @(negedge CLOCK);
      ena_wr = 1'b0; ena_rd = 1'b0; addr = $urandom; wdata = $urandom;
      bus_gnt    = (i == gnt_dly);
      bus_rvalid = (i == gnt_dly) && !wr && (rv_dly == 0);
      bus_rdata  = bus_rvalid ? rword : $urandom;
      #1;
      check1("req", bus_req, 1'b1);
      check1("req_we", bus_we, wr);
      check32("req_addr", bus_addr, a & 32'hFFFF_FFFC);
      check32("req_be", 32'(bus_be), 32'(m_be(wr, f3, a)));
      check32("req_wdata", bus_wdata, m_wdata(wr, f3, wd));
      if (lsu_stall) stall_cycles++;
    end

    if (!wr) begin
      for (int i = 1; i <= rv_dly; i++) begin
        @(negedge CLOCK);
        bus_gnt    = 1'($urandom);
        bus_rvalid = (i == rv_dly);
        bus_rdata  = bus_rvalid ? rword : $urandom;
        #1;
        check1("wait_req_low", bus_req, 1'b0);
        if (lsu_stall) stall_cycles++;
      end
    end

    @(negedge CLOCK);
    bus_gnt    = 1'b0;
    bus_rvalid = 1'($urandom);
    bus_rdata  = $urandom;
    #1;
    if (!wr) model_rdata = ld_e;
    check1("done_stall", lsu_stall, 1'b0);
    check1("done_req", bus_req, 1'b0);
    check32("done_rdata", rdata, model_rdata);
    check32("stall_cycles", stall_cycles, 2 + gnt_dly + (wr ? 0 : rv_dly));

    @(negedge CLOCK);
    bus_rvalid = 1'b0;
    #1;
    check1("after_stall", lsu_stall, 1'b0);
    check32("rdata_hold", rdata, model_rdata);
  endtask

  initial begin
    checks = 0; errors = 0; model_rdata = 32'h0;
    RST_n = 1'b0; ena_rd = 1'b0; ena_wr = 1'b0; addr = 32'h0; wdata = 32'h0;
    funct3 = 3'b000; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;

    #12;
    check1("rst_req", bus_req, 1'b0);
    check1("rst_we", bus_we, 1'b0);
    check32("rst_addr", bus_addr, 32'h0);
    check32("rst_be", 32'(bus_be), 32'h0);
    check32("rst_wdata", bus_wdata, 32'h0);
    check32("rst_rdata", rdata, 32'h0);
    check1("rst_fault", lsu_fault, 1'b0);
    check1("rst_stall_idle", lsu_stall, 1'b0);
    ena_rd = 1'b1; funct3 = 3'b010; addr = 32'h40;
    #1;
    check1("rst_stall_valid_req", lsu_stall, 1'b1);
    ena_rd = 1'b0;
    @(negedge CLOCK);
    RST_n = 1'b1;

    // Directed cases
    run_access(1'b1, 1'b0, 32'h100, 32'hDEAD_BEEF, 3'b010, 0, 0, 32'h0);
    run_access(1'b0, 1'b1, 32'h203, 32'h0, 3'b000, 0, 2, 32'h80FF_1234);
    check32("lb_result", rdata, 32'hFFFF_FF80);
    run_access(1'b0, 1'b1, 32'h202, 32'h0, 3'b101, 0, 0, 32'h8001_0000);
    check32("lhu_result", rdata, 32'h0000_8001);
    run_access(1'b1, 1'b0, 32'h11, 32'h0000_00AB, 3'b000, 1, 0, 32'h0);
    run_access(1'b0, 1'b1, 32'h102, 32'h0, 3'b010, 0, 0, 32'h0);
    run_access(1'b1, 1'b0, 32'h200, 32'h1234_5678, 3'b011, 0, 0, 32'h0);
    run_access(1'b1, 1'b1, 32'h206, 32'hCAFE_F00D, 3'b001, 2, 0, 32'h0);

    // Reset during WAIT_R aborts the load
    @(negedge CLOCK);
    ena_rd = 1'b1; addr = 32'h40; funct3 = 3'b010;
    @(negedge CLOCK);
    ena_rd = 1'b0; bus_gnt = 1'b1;
    @(negedge CLOCK);
    bus_gnt = 1'b0;
    #1;
    check1("wait_before_rst", lsu_stall, 1'b1);
    RST_n = 1'b0;
    #1;
    model_rdata = 32'h0;
    check1("abort_req", bus_req, 1'b0);
    check1("abort_stall", lsu_stall, 1'b0);
    check32("abort_rdata", rdata, 32'h0);
    @(negedge CLOCK);
    RST_n = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'h5555_AAAA;
    @(negedge CLOCK);
    bus_rvalid = 1'b0;
    #1;
    check32("abort_no_completion", rdata, 32'h0);
    check1("abort_idle", lsu_stall, 1'b0);
    run_access(1'b0, 1'b1, 32'h44, 32'h0, 3'b010, 1, 1, 32'h0BAD_CAFE);

    // Random accesses
    for (int n = 0; n < 60; n++) begin
      logic        r_wr;
      logic        r_rd;
      logic [31:0] r_a;
      r_wr = 1'($urandom);
      r_rd = r_wr ? 1'($urandom) : 1'b1;
      r_a  = $urandom;
      if ($urandom_range(0, 2) != 0) r_a[1:0] = 2'b00;
      run_access(r_wr, r_rd, r_a, $urandom, 3'($urandom),
                 $urandom_range(0, 2), $urandom_range(0, 2), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
